// File: rtl/calc_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, default
// sizing and the decimal range limit helper.
package calc_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    DESPLAZA,
    FIN
  } estado_t;

  localparam int DIGITOS_DEF   = 5;
  localparam int ANCHO_BIN_DEF = 17;
  localparam int MAX_DECIMAL   = 99999;

  // Largest value representable with the given number of decimal digits.
  function automatic logic [63:0] max_decimal(input int digitos);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digitos; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/ajuste_digito.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decade.
module ajuste_digito (
  input  logic [3:0] digito,
  output logic [3:0] ajustado
);

  assign ajustado = (digito >= 4'd5) ? digito + 4'd3 : digito;

endmodule

// File: rtl/convertidor_binario_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional macro RANGO_CHECK_EN: saturate to all 9s and flag error_rango.
module convertidor_binario_bcd
  import calc_pkg::*;
#(
  parameter int DIGITOS   = DIGITOS_DEF,
  parameter int ANCHO_BIN = ANCHO_BIN_DEF
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [ANCHO_BIN-1:0]   entrada_bin,
  output logic [4*DIGITOS-1:0]   resultado_bcd,
  output logic                   terminado,
  output logic                   ocupado,
  output logic                   error_rango
);

  localparam int                   ANCHO_CNT = $clog2(ANCHO_BIN + 1);
  localparam logic [ANCHO_CNT-1:0] PASOS     = ANCHO_CNT'(ANCHO_BIN);
  localparam logic [ANCHO_CNT-1:0] UNO       = ANCHO_CNT'(1);

  estado_t                estado;
  logic [ANCHO_CNT-1:0]   contador;
  logic [ANCHO_BIN-1:0]   operando;
  logic [4*DIGITOS-1:0]   acumulador;
  logic [4*DIGITOS-1:0]   ajustado;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .digito  (acumulador[4*g +: 4]),
      .ajustado(ajustado[4*g +: 4])
    );
  end

`ifdef RANGO_CHECK_EN
  localparam logic [63:0] LIMITE = max_decimal(DIGITOS);
  logic fuera_rango;
`else
  assign error_rango = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let the shift read its own new result.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      estado        <= REPOSO;
      contador      <= '0;
      operando      <= '0;
      acumulador    <= '0;
      resultado_bcd <= '0;
      terminado     <= 1'b0;
      ocupado       <= 1'b0;
`ifdef RANGO_CHECK_EN
      fuera_rango   <= 1'b0;
      error_rango   <= 1'b0;
`endif
    end else begin
      terminado <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            operando   <= entrada_bin;
            acumulador <= '0;
            contador   <= PASOS;
            ocupado    <= 1'b1;
            estado     <= DESPLAZA;
`ifdef RANGO_CHECK_EN
            fuera_rango <= 64'(entrada_bin) > LIMITE;
`endif
          end
        end
        DESPLAZA: begin
          // {digits, operand} shift as one register; the carry spilled out of
          // the top digit refills the operand LSB and never reaches its MSB
          // before the count runs out, so it is effectively discarded.
          acumulador <= {ajustado[4*DIGITOS-2:0], operando[ANCHO_BIN-1]};
          operando   <= {operando[ANCHO_BIN-2:0], ajustado[4*DIGITOS-1]};
          contador   <= contador - UNO;
          if (contador == UNO) estado <= FIN;
        end
        FIN: begin
          terminado <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= REPOSO;
`ifdef RANGO_CHECK_EN
          error_rango   <= fuera_rango;
          resultado_bcd <= fuera_rango ? {DIGITOS{4'h9}} : acumulador;
`else
          resultado_bcd <= acumulador;
`endif
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// Self-checking bench for convertidor_binario_bcd: an arithmetic reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_convertidor_binario_bcd;

  logic        reloj = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [16:0] entrada_bin = '0;
  logic [19:0] resultado_bcd;
  logic        terminado;
  logic        ocupado;
  logic        error_rango;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  convertidor_binario_bcd dut (
    .reloj        (reloj),
    .reset        (reset),
    .inicio       (inicio),
    .entrada_bin  (entrada_bin),
    .resultado_bcd(resultado_bcd),
    .terminado    (terminado),
    .ocupado      (ocupado),
    .error_rango  (error_rango)
  );

  initial forever #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  task automatic check(input string nombre, input logic [31:0] obtenido,
                       input logic [31:0] requerido);
    n_tests++;
    if (obtenido !== requerido) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nombre, obtenido, requerido, $time);
    end
  endtask

  function automatic logic [19:0] a_bcd(input int unsigned d);
    logic [19:0] r;
    int unsigned x;
    x = d;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned bcd_a_bin(input logic [19:0] b);
    int unsigned s;
    s = 0;
    for (int i = 4; i >= 0; i--) s = s * 10 + int'(b[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [19:0] esperado_bcd(input logic [16:0] v);
`ifdef RANGO_CHECK_EN
    return (int'(v) > 99999) ? 20'h99999 : a_bcd(int'(v));
`else
    return a_bcd(int'(v) % 100000);
`endif
  endfunction

  function automatic logic esperado_err(input logic [16:0] v);
`ifdef RANGO_CHECK_EN
    return int'(v) > 99999;
`else
    return (v === 17'h1FFFF) && 1'b0;
`endif
  endfunction

  // Reference model: a request taken while idle completes 18 edges later.
  logic        m_busy, m_term, m_err;
  logic [19:0] m_res;
  logic [16:0] m_op;
  int          m_cnt;

  always @(posedge reloj or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_term <= 1'b0; m_err <= 1'b0;
      m_res  <= '0;   m_op   <= '0;   m_cnt <= 0;
    end else begin
      m_term <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 17) begin
          m_busy <= 1'b0;
          m_term <= 1'b1;
          m_res  <= esperado_bcd(m_op);
          m_err  <= esperado_err(m_op);
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (inicio) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_op   <= entrada_bin;
      end
    end
  end

  always @(negedge reloj) begin
    check("model_ocupado", 32'(ocupado), 32'(m_busy));
    check("model_terminado", 32'(terminado), 32'(m_term));
    check("model_resultado", 32'(resultado_bcd), 32'(m_res));
    check("model_error", 32'(error_rango), 32'(m_err));
  end

  task automatic run_conv(input logic [16:0] v, input logic [19:0] exp_bcd,
                          input logic exp_err, input string nombre);
    int lat;
    bit visto;
    @(negedge reloj);
    entrada_bin = v;
    inicio      = 1'b1;
    @(posedge reloj);
    lat   = 0;
    visto = 1'b0;
    for (int i = 1; i <= 40 && !visto; i++) begin
      @(posedge reloj);
      #1;
      if (i == 1) begin
        inicio      = 1'b0;
        entrada_bin = ~v;
      end
      if (terminado) begin
        visto = 1'b1;
        lat   = i;
      end
    end
    check({nombre, "_pulse_seen"}, 32'(visto), 32'd1);
    check({nombre, "_latency"}, 32'(lat), 32'd18);
    check({nombre, "_bcd"}, 32'(resultado_bcd), 32'(exp_bcd));
    check({nombre, "_err"}, 32'(error_rango), 32'(exp_err));
  endtask

  initial begin
    int          pulsos[$];
    logic [19:0] res_pulsos[$];
    bit          visto;

    repeat (2) @(negedge reloj);
    #2;
    check("reset_bcd", 32'(resultado_bcd), 32'h0);
    check("reset_terminado", 32'(terminado), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);
    check("reset_error", 32'(error_rango), 32'h0);
    @(negedge reloj);
    reset = 1'b1;
    repeat (3) @(negedge reloj);
    check("idle_ocupado", 32'(ocupado), 32'h0);
    check("idle_bcd", 32'(resultado_bcd), 32'h0);

    run_conv(17'd35789, 20'h35789, 1'b0, "conv_35789");
    check("roundtrip_35789", bcd_a_bin(resultado_bcd), 32'd35789);
    run_conv(17'd0, 20'h00000, 1'b0, "conv_0");
    run_conv(17'd99999, 20'h99999, 1'b0, "conv_99999");
    run_conv(17'd1, 20'h00001, 1'b0, "conv_1");
`ifdef RANGO_CHECK_EN
    run_conv(17'd100000, 20'h99999, 1'b1, "conv_100000");
    run_conv(17'd131071, 20'h99999, 1'b1, "conv_131071");
`else
    run_conv(17'd100000, 20'h00000, 1'b0, "conv_100000");
    run_conv(17'd131071, 20'h31071, 1'b0, "conv_131071");
`endif
    run_conv(17'd4095, 20'h04095, 1'b0, "conv_4095");

    // Back-to-back conversions with inicio held high; operand changed mid-flight.
    @(negedge reloj);
    entrada_bin = 17'd12345;
    inicio      = 1'b1;
    for (int i = 0; i < 90 && pulsos.size() < 3; i++) begin
      @(posedge reloj);
      #1;
      if (i == 9) entrada_bin = 17'd54321;
      if (terminado) begin
        pulsos.push_back(cyc);
        res_pulsos.push_back(resultado_bcd);
        if (pulsos.size() == 3) inicio = 1'b0;
      end
    end
    inicio = 1'b0;
    check("b2b_pulse_count", 32'(pulsos.size()), 32'd3);
    if (pulsos.size() == 3) begin
      check("b2b_period_1", 32'(pulsos[1] - pulsos[0]), 32'd19);
      check("b2b_period_2", 32'(pulsos[2] - pulsos[1]), 32'd19);
      check("b2b_first_result", 32'(res_pulsos[0]), 32'h12345);
      check("b2b_second_result", 32'(res_pulsos[1]), 32'h54321);
      check("b2b_third_result", 32'(res_pulsos[2]), 32'h54321);
    end

    // Asynchronous reset during shift cycle 9 of a conversion.
    repeat (2) @(negedge reloj);
    entrada_bin = 17'd99999;
    inicio      = 1'b1;
    @(posedge reloj);
    #1;
    inicio = 1'b0;
    repeat (9) @(posedge reloj);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_bcd", 32'(resultado_bcd), 32'h0);
    check("midreset_ocupado", 32'(ocupado), 32'h0);
    check("midreset_terminado", 32'(terminado), 32'h0);
    check("midreset_error", 32'(error_rango), 32'h0);
    @(negedge reloj);
    reset = 1'b1;
    visto = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge reloj);
      #1;
      if (terminado || ocupado) visto = 1'b1;
    end
    check("midreset_no_activity", 32'(visto), 32'd0);

    run_conv(17'd35789, 20'h35789, 1'b0, "recover_35789");

    repeat (2) @(negedge reloj);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
